// File: rtl/smg_scan_controller.sv
// Scan controller for a 6-digit common-anode seven-segment display.
// Strobes one digit at a time with blanking gaps and latches new values only between frames.
module smg_scan_controller #(
  parameter int T_DIGIT     = 50000,
  parameter int T_BLANK     = 500,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] Number_Sig,
  input  logic [5:0]  Dot_Mask,
  input  logic        Load_Req,
  output logic        Load_Ack,
  output logic [5:0]  Scan_Sel,
  output logic [7:0]  Seg_Out,
  output logic        Frame_Done
);

  localparam int T_MAX = (T_DIGIT > T_BLANK) ? T_DIGIT : T_BLANK;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CW-1:0] DIGIT_LAST = CW'(T_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(T_BLANK - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [23:0]   shadow_val, shadow_val_n;
  logic [5:0]    shadow_mask, shadow_mask_n;
  logic          ack_n, done_n;
  logic [5:0]    scan_n;
  logic [7:0]    seg_n;
  logic [3:0]    nib;
  logic [5:0]    zero_above;
  logic          suppress;

  // Active-low a-g pattern; non-decimal nibbles show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] b);
    case (b)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= 3'd0;
      shadow_val  <= 24'd0;
      shadow_mask <= 6'd0;
      Load_Ack    <= 1'b0;
      Frame_Done  <= 1'b0;
      Scan_Sel    <= 6'h3F;
      Seg_Out     <= 8'hFF;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shadow_val  <= shadow_val_n;
      shadow_mask <= shadow_mask_n;
      Load_Ack    <= ack_n;
      Frame_Done  <= done_n;
      Scan_Sel    <= scan_n;
      Seg_Out     <= seg_n;
    end
  end

  // Outputs are decoded from the next-state values so the registered pins line up with the state.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt + CW'(1);
    idx_n         = idx;
    shadow_val_n  = shadow_val;
    shadow_mask_n = shadow_mask;
    ack_n         = 1'b0;
    done_n        = 1'b0;
    scan_n        = 6'h3F;
    seg_n         = 8'hFF;
    nib           = 4'd0;
    zero_above    = 6'd0;
    suppress      = 1'b0;

    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DIGIT_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          if (idx == 3'd5) begin
            idx_n  = 3'd0;
            done_n = 1'b1;
            if (Load_Req) begin
              shadow_val_n  = Number_Sig;
              shadow_mask_n = Dot_Mask;
              ack_n         = 1'b1;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase

    for (int k = 0; k < 6; k++) begin
      zero_above[k] = ((shadow_val_n >> (4 * k)) == 24'd0);
    end

    if (state_n == ST_SHOW) begin
      nib      = shadow_val_n[{idx_n, 2'b00} +: 4];
      suppress = LZ_SUPPRESS && (idx_n != 3'd0) && zero_above[idx_n];
      seg_n    = {~shadow_mask_n[idx_n], suppress ? 7'h7F : bcd_to_seg(nib)};
      if (!suppress || shadow_mask_n[idx_n]) begin
        scan_n = ~(6'b000001 << idx_n);
      end
    end
  end

endmodule
